// File: rtl/aes256_round_seq_if.sv
// Handshake bundle between the AES-256 round sequencer and its environment
// (top-level start/done control plus the inter-round state register).
interface aes256_round_seq_if;
  logic       start;
  logic       abort;
  logic       reg_full;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic       in_sel;
  logic [3:0] round_idx;
  logic       last_round;
  logic       key_req;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    input  start, abort, reg_full,
    output reg_wr_en, reg_rd_en, in_sel, round_idx, last_round,
           key_req, busy, done, err
  );

  modport slave (
    output start, abort, reg_full,
    input  reg_wr_en, reg_rd_en, in_sel, round_idx, last_round,
           key_req, busy, done, err
  );
endinterface

// File: rtl/aes256_round_seq.sv
// AES-256 round sequencer: walks rounds 0..NR through write / wait-full /
// read / compute, with timeout, abort and Moore-registered outputs.
module aes256_round_seq #(
  parameter int NR      = 14,
  parameter int DP_LAT  = 2,
  parameter int TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               resetn,
  aes256_round_seq_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WRITE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_READ    = 3'd3;
  localparam logic [2:0] S_COMPUTE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  // One counter serves both the WAIT_FULL timeout and the COMPUTE latency.
  localparam int              CNT_MAX  = (TIMEOUT > DP_LAT) ? TIMEOUT : DP_LAT;
  localparam int              CW       = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]   TO_LIM   = CW'(TIMEOUT);
  localparam logic [CW-1:0]   LAT_LAST = CW'(DP_LAT - 1);
  localparam logic [3:0]      LAST     = 4'(NR);

  logic [2:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    round, round_d;
  logic          in_sel_q, in_sel_d;
  logic          err_q, err_d;
  logic          wr_q, rd_q, key_q, busy_q, done_q;
  logic          run_state;

  assign run_state = (state == S_WRITE) || (state == S_WAIT) ||
                     (state == S_READ)  || (state == S_COMPUTE);

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d  = state;
    cnt_d    = cnt;
    round_d  = round;
    in_sel_d = in_sel_q;
    err_d    = err_q;
    case (state)
      S_IDLE, S_ERROR: begin
        // abort only matters in IDLE here; in ERROR it has no effect
        if (bus.start && !(state == S_IDLE && bus.abort)) begin
          state_d  = S_WRITE;
          round_d  = '0;
          in_sel_d = 1'b0;
          err_d    = 1'b0;
        end
      end
      S_WRITE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (bus.reg_full) begin
          state_d = S_READ;
        end else begin
          cnt_d = cnt + 1'b1;
          if (cnt_d == TO_LIM) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      S_READ: begin
        state_d = S_COMPUTE;
        cnt_d   = '0;
      end
      S_COMPUTE: begin
        if (cnt == LAT_LAST) begin
          if (round == LAST) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_WRITE;
            round_d  = round + 4'd1;
            in_sel_d = 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort freezes round/in_sel so the aborted position stays visible.
    if (bus.abort && run_state) begin
      state_d  = S_IDLE;
      cnt_d    = cnt;
      round_d  = round;
      in_sel_d = in_sel_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      round    <= '0;
      in_sel_q <= 1'b0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      key_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
      state    <= state_d;
      cnt      <= cnt_d;
      round    <= round_d;
      in_sel_q <= in_sel_d;
      err_q    <= err_d;
      // Outputs decode the next state so they line up with the state register.
      wr_q     <= (state_d == S_WRITE);
      rd_q     <= (state_d == S_READ);
      key_q    <= (state_d == S_COMPUTE) && (cnt_d == '0) && (round_d != LAST);
      busy_q   <= (state_d != S_IDLE) && (state_d != S_ERROR);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign bus.reg_wr_en  = wr_q;
  assign bus.reg_rd_en  = rd_q;
  assign bus.in_sel     = in_sel_q;
  assign bus.round_idx  = round;
  assign bus.last_round = (round == LAST);
  assign bus.key_req    = key_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_aes256_round_seq.sv
// Directed bench for aes256_round_seq: default DUT plus DP_LAT=1 and DP_LAT=4
// instances, each with a one-cycle state-register model.
module tb_aes256_round_seq;

  logic clk;
  logic resetn;
  logic hold_empty;
  logic full0, full1, full4;
  int   total;
  int   bad;

  aes256_round_seq_if bus0 ();
  aes256_round_seq_if bus1 ();
  aes256_round_seq_if bus4 ();

  aes256_round_seq #(.NR(14), .DP_LAT(2), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn), .bus(bus0));
  aes256_round_seq #(.NR(14), .DP_LAT(1), .TIMEOUT(8)) dut_lat1 (
    .clk(clk), .resetn(resetn), .bus(bus1));
  aes256_round_seq #(.NR(14), .DP_LAT(4), .TIMEOUT(8)) dut_lat4 (
    .clk(clk), .resetn(resetn), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register model: full the edge after a write, empty the edge after a read.
  always @(posedge clk or negedge resetn) begin
    if (!resetn)                full0 <= 1'b0;
    else if (hold_empty)        full0 <= 1'b0;
    else if (bus0.reg_wr_en)    full0 <= 1'b1;
    else if (bus0.reg_rd_en)    full0 <= 1'b0;
  end
  always @(posedge clk or negedge resetn) begin
    if (!resetn)                full1 <= 1'b0;
    else if (bus1.reg_wr_en)    full1 <= 1'b1;
    else if (bus1.reg_rd_en)    full1 <= 1'b0;
  end
  always @(posedge clk or negedge resetn) begin
    if (!resetn)                full4 <= 1'b0;
    else if (bus4.reg_wr_en)    full4 <= 1'b1;
    else if (bus4.reg_rd_en)    full4 <= 1'b0;
  end
  assign bus0.reg_full = full0;
  assign bus1.reg_full = full1;
  assign bus4.reg_full = full4;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts an operation on the default DUT and observes it cycle by cycle.
  // stop_kind 1: abort in the first COMPUTE cycle of stop_round.
  // stop_kind 2: return in the WAIT_FULL cycle of stop_round.
  task automatic run_op(input int stop_kind, input int stop_round, input bit noise,
                        output int cyc, output int n_wr, output int n_rd,
                        output int n_key, output int n_last, output int n_bad,
                        output bit got_done, output bit stopped);
    bit prev_wr, prev_rd;
    cyc = -1; n_wr = 0; n_rd = 0; n_key = 0; n_last = 0; n_bad = 0;
    got_done = 1'b0; stopped = 1'b0; prev_wr = 1'b0; prev_rd = 1'b0;
    for (int k = 0; k < 4 && (bus0.busy || bus0.done); k++) step();
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    for (int t = 0; t < 300; t++) begin
      bus0.start = 1'b0;
      if (bus0.reg_wr_en) begin
        if (bus0.round_idx !== 4'(n_wr) || bus0.in_sel !== (n_wr != 0)) n_bad++;
        n_wr++;
      end
      if (bus0.reg_rd_en) n_rd++;
      if (bus0.key_req) n_key++;
      if (bus0.last_round) n_last++;
      if ((bus0.reg_wr_en && bus0.reg_rd_en) || (bus0.reg_wr_en && prev_wr) ||
          (bus0.reg_rd_en && prev_rd)) n_bad++;
      if (bus0.last_round !== (bus0.round_idx == 4'd14)) n_bad++;
      if (bus0.busy !== 1'b1 || bus0.err !== 1'b0) n_bad++;
      prev_wr = bus0.reg_wr_en;
      prev_rd = bus0.reg_rd_en;
      if (bus0.done) begin
        got_done = 1'b1;
        cyc = t;
        break;
      end
      if (stop_kind == 1 && bus0.key_req && bus0.round_idx == 4'(stop_round)) begin
        bus0.abort = 1'b1;
        step();
        bus0.abort = 1'b0;
        stopped = 1'b1;
        cyc = t + 1;
        break;
      end
      if (stop_kind == 2 && bus0.reg_wr_en && bus0.round_idx == 4'(stop_round)) begin
        step();
        stopped = 1'b1;
        cyc = t + 1;
        break;
      end
      if (noise && bus0.key_req && (bus0.round_idx == 4'd3 || bus0.round_idx == 4'd9))
        bus0.start = 1'b1;
      step();
    end
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #2;
    obs = {bus0.reg_wr_en, bus0.reg_rd_en, bus0.in_sel, bus0.round_idx,
           bus0.last_round, bus0.key_req, bus0.busy, bus0.done, bus0.err};
    total++;
    if (obs !== 12'h000) begin
      bad++; $display("FAIL reset_outputs: got %b want %b", obs, 12'h000);
    end
    obs = {bus4.reg_wr_en, bus4.reg_rd_en, bus4.in_sel, bus4.round_idx,
           bus4.last_round, bus4.key_req, bus4.busy, bus4.done, bus4.err};
    total++;
    if (obs !== 12'h000) begin
      bad++; $display("FAIL reset_outputs_lat4: got %b want %b", obs, 12'h000);
    end
    step(); step();
    resetn = 1'b1;
    step(); step();
    total++;
    if (bus0.busy !== 1'b0 || bus0.round_idx !== 4'd0) begin
      bad++; $display("FAIL reset_idle: busy=%b round=%0d want busy=0 round=0",
                      bus0.busy, bus0.round_idx);
    end
  endtask

  task automatic test_nominal();
    int cyc, n_wr, n_rd, n_key, n_last, n_bad;
    bit got_done, stopped;
    run_op(0, 0, 1'b0, cyc, n_wr, n_rd, n_key, n_last, n_bad, got_done, stopped);
    total++;
    if (cyc !== 75) begin bad++; $display("FAIL nominal_latency: got %0d want 75", cyc); end
    total++;
    if (n_wr !== 15 || n_rd !== 15) begin
      bad++; $display("FAIL nominal_wr_rd: got wr=%0d rd=%0d want 15/15", n_wr, n_rd);
    end
    total++;
    if (n_key !== 14) begin bad++; $display("FAIL nominal_key_req: got %0d want 14", n_key); end
    total++;
    if (n_last !== 6) begin bad++; $display("FAIL nominal_last_round_cycles: got %0d want 6", n_last); end
    total++;
    if (n_bad !== 0) begin bad++; $display("FAIL nominal_sequence: got %0d violations want 0", n_bad); end
    step();
    total++;
    if (bus0.done !== 1'b0 || bus0.busy !== 1'b0) begin
      bad++; $display("FAIL nominal_after_done: done=%b busy=%b want 0/0", bus0.done, bus0.busy);
    end
    total++;
    if (bus0.round_idx !== 4'd14 || bus0.last_round !== 1'b1) begin
      bad++; $display("FAIL nominal_round_hold: round=%0d last=%b want 14/1",
                      bus0.round_idx, bus0.last_round);
    end
  endtask

  task automatic test_timeout();
    int cyc, n_wr, n_rd, n_key, n_last, n_bad;
    bit got_done, stopped, saw_done;
    hold_empty = 1'b1;
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    saw_done = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (bus0.done) saw_done = 1'b1;
    end
    total++;
    if (bus0.err !== 1'b0 || bus0.busy !== 1'b1) begin
      bad++; $display("FAIL timeout_early: err=%b busy=%b want 0/1", bus0.err, bus0.busy);
    end
    step();
    total++;
    if (bus0.err !== 1'b1 || bus0.busy !== 1'b0 || bus0.done !== 1'b0 || saw_done) begin
      bad++; $display("FAIL timeout_error: err=%b busy=%b done=%b want 1/0/0",
                      bus0.err, bus0.busy, bus0.done);
    end
    bus0.abort = 1'b1;
    step();
    bus0.abort = 1'b0;
    step(); step();
    total++;
    if (bus0.err !== 1'b1 || bus0.busy !== 1'b0) begin
      bad++; $display("FAIL timeout_sticky: err=%b busy=%b want 1/0", bus0.err, bus0.busy);
    end
    hold_empty = 1'b0;
    run_op(0, 0, 1'b0, cyc, n_wr, n_rd, n_key, n_last, n_bad, got_done, stopped);
    total++;
    if (cyc !== 75 || n_bad !== 0 || n_wr !== 15) begin
      bad++; $display("FAIL timeout_recovery: cyc=%0d viol=%0d wr=%0d want 75/0/15",
                      cyc, n_bad, n_wr);
    end
    step();
  endtask

  task automatic test_abort();
    int cyc, n_wr, n_rd, n_key, n_last, n_bad;
    bit got_done, stopped, leak;
    run_op(1, 5, 1'b0, cyc, n_wr, n_rd, n_key, n_last, n_bad, got_done, stopped);
    total++;
    if (!stopped || got_done || n_wr !== 6) begin
      bad++; $display("FAIL abort_reached: stopped=%b done=%b wr=%0d want 1/0/6",
                      stopped, got_done, n_wr);
    end
    total++;
    if (bus0.busy !== 1'b0 || bus0.reg_wr_en !== 1'b0 || bus0.reg_rd_en !== 1'b0 ||
        bus0.done !== 1'b0 || bus0.key_req !== 1'b0) begin
      bad++; $display("FAIL abort_idle: busy=%b wr=%b rd=%b done=%b key=%b want all 0",
                      bus0.busy, bus0.reg_wr_en, bus0.reg_rd_en, bus0.done, bus0.key_req);
    end
    total++;
    if (bus0.round_idx !== 4'd5) begin
      bad++; $display("FAIL abort_round_hold: got %0d want 5", bus0.round_idx);
    end
    leak = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus0.done || bus0.busy) leak = 1'b1;
    end
    total++;
    if (leak) begin bad++; $display("FAIL abort_no_done: got activity want none"); end
    run_op(0, 0, 1'b0, cyc, n_wr, n_rd, n_key, n_last, n_bad, got_done, stopped);
    total++;
    if (cyc !== 75 || n_bad !== 0 || n_wr !== 15) begin
      bad++; $display("FAIL abort_rerun: cyc=%0d viol=%0d wr=%0d want 75/0/15", cyc, n_bad, n_wr);
    end
    step();
  endtask

  task automatic test_ignored_start();
    int cyc, n_wr, n_rd, n_key, n_last, n_bad;
    bit got_done, stopped;
    run_op(0, 0, 1'b1, cyc, n_wr, n_rd, n_key, n_last, n_bad, got_done, stopped);
    total++;
    if (cyc !== 75 || n_bad !== 0 || n_wr !== 15 || n_key !== 14) begin
      bad++; $display("FAIL ignored_start: cyc=%0d viol=%0d wr=%0d key=%0d want 75/0/15/14",
                      cyc, n_bad, n_wr, n_key);
    end
    step();
    bus0.start = 1'b1;
    bus0.abort = 1'b1;
    step();
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    total++;
    if (bus0.busy !== 1'b0 || bus0.reg_wr_en !== 1'b0) begin
      bad++; $display("FAIL start_abort_collision: busy=%b wr=%b want 0/0",
                      bus0.busy, bus0.reg_wr_en);
    end
    step();
    total++;
    if (bus0.busy !== 1'b0 || bus0.round_idx !== 4'd14) begin
      bad++; $display("FAIL collision_hold: busy=%b round=%0d want 0/14",
                      bus0.busy, bus0.round_idx);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, n_wr, n_rd, n_key, n_last, n_bad;
    bit got_done, stopped;
    logic [11:0] obs;
    run_op(2, 7, 1'b0, cyc, n_wr, n_rd, n_key, n_last, n_bad, got_done, stopped);
    total++;
    if (!stopped || bus0.busy !== 1'b1 || bus0.reg_wr_en !== 1'b0 || bus0.round_idx !== 4'd7) begin
      bad++; $display("FAIL reset_mid_setup: stopped=%b busy=%b wr=%b round=%0d want 1/1/0/7",
                      stopped, bus0.busy, bus0.reg_wr_en, bus0.round_idx);
    end
    #2 resetn = 1'b0;
    #1;
    obs = {bus0.reg_wr_en, bus0.reg_rd_en, bus0.in_sel, bus0.round_idx,
           bus0.last_round, bus0.key_req, bus0.busy, bus0.done, bus0.err};
    total++;
    if (obs !== 12'h000) begin
      bad++; $display("FAIL reset_mid_async: got %b want %b", obs, 12'h000);
    end
    @(posedge clk);
    #2 resetn = 1'b1;
    step();
    run_op(0, 0, 1'b0, cyc, n_wr, n_rd, n_key, n_last, n_bad, got_done, stopped);
    total++;
    if (cyc !== 75 || n_bad !== 0 || n_wr !== 15) begin
      bad++; $display("FAIL reset_mid_rerun: cyc=%0d viol=%0d wr=%0d want 75/0/15", cyc, n_bad, n_wr);
    end
    step();
  endtask

  task automatic test_sweep();
    int lat[2], last_rd[2], done_t[2], gaps[2], badgap[2];
    logic [1:0] wr, rd, dn;
    lat = '{1, 4};
    last_rd = '{-1, -1};
    done_t = '{-1, -1};
    gaps = '{0, 0};
    badgap = '{0, 0};
    bus1.start = 1'b1;
    bus4.start = 1'b1;
    step();
    bus1.start = 1'b0;
    bus4.start = 1'b0;
    for (int t = 0; t < 200 && (done_t[0] < 0 || done_t[1] < 0); t++) begin
      wr = {bus4.reg_wr_en, bus1.reg_wr_en};
      rd = {bus4.reg_rd_en, bus1.reg_rd_en};
      dn = {bus4.done, bus1.done};
      for (int i = 0; i < 2; i++) begin
        if ((wr[i] || dn[i]) && last_rd[i] >= 0) begin
          gaps[i]++;
          if (t - last_rd[i] != lat[i] + 1) badgap[i]++;
          last_rd[i] = -1;
        end
        if (rd[i]) last_rd[i] = t;
        if (dn[i] && done_t[i] < 0) done_t[i] = t;
      end
      step();
    end
    total++;
    if (done_t[0] !== 60) begin bad++; $display("FAIL sweep_lat1_done: got %0d want 60", done_t[0]); end
    total++;
    if (done_t[1] !== 105) begin bad++; $display("FAIL sweep_lat4_done: got %0d want 105", done_t[1]); end
    total++;
    if (gaps[0] !== 15 || badgap[0] !== 0) begin
      bad++; $display("FAIL sweep_lat1_compute: passes=%0d bad=%0d want 15/0", gaps[0], badgap[0]);
    end
    total++;
    if (gaps[1] !== 15 || badgap[1] !== 0) begin
      bad++; $display("FAIL sweep_lat4_compute: passes=%0d bad=%0d want 15/0", gaps[1], badgap[1]);
    end
    step();
    total++;
    if (bus1.busy !== 1'b0 || bus4.busy !== 1'b0) begin
      bad++; $display("FAIL sweep_idle: busy1=%b busy4=%b want 0/0", bus1.busy, bus4.busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    hold_empty = 1'b0;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    bus4.start = 1'b0; bus4.abort = 1'b0;
    test_reset();
    test_nominal();
    test_timeout();
    test_abort();
    test_ignored_start();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes256_round_seq.md
Name: aes256_round_seq

Overview:
- Round sequencer for the AES-256 core.
- Drives the write/read handshake of the 16-byte inter-round state register and selects whether the plaintext or the round result is loaded.
- Tracks the round index 0..NR and flags the final round, which skips MixColumns.
- Sits between the top-level start/done interface and the round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey plus state register).

Parameters:
- NR, 14, index of the last round; total passes = NR+1 (round 0 = initial AddRoundKey).
- DP_LAT, 2, cycles the round datapath needs after a register read before its result is valid; legal range ≥1.
- TIMEOUT, 8, maximum cycles spent in WAIT_FULL before an error is declared; legal range ≥1.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle request to begin an encryption; sampled only in IDLE.
- abort  in  1  cancels the operation in progress; returns to IDLE next edge.
- reg_full  in  1  state-register full flag.
- reg_wr_en  out  1  state-register write enable.
- reg_rd_en  out  1  state-register read enable.
- in_sel  out  1  register input mux: 0 = plaintext, 1 = round result.
- round_idx  out  4  current round number, 0..NR.
- last_round  out  1  high while round_idx==NR (datapath bypasses MixColumns).
- key_req  out  1  one-cycle pulse requesting round key round_idx+1.
- busy  out  1  high in every state except IDLE and ERROR.
- done  out  1  one-cycle pulse on completion.
- err  out  1  sticky timeout flag.

Behaviour:
- All outputs are registered, Moore style, and decoded from state plus counters.
- Reset, asynchronous: state=IDLE, round_idx=0, all outputs 0.
- A reset assertion mid-operation aborts immediately with no done.

States and transitions:
- IDLE: start=1 → WRITE; round_idx←0, in_sel←0, err←0.
- WRITE: one cycle, reg_wr_en=1 → WAIT_FULL; timeout counter cleared.
- WAIT_FULL: reg_full=1 → READ. Otherwise the counter increments; when it reaches TIMEOUT → ERROR.
- READ: one cycle, reg_rd_en=1 → COMPUTE; latency counter cleared.
- COMPUTE: exactly DP_LAT cycles.
  - key_req=1 in the first COMPUTE cycle only, suppressed when round_idx==NR.
  - On exit: if round_idx==NR → DONE; else round_idx+1, in_sel←1, → WRITE.
- DONE: one cycle, done=1 → IDLE. round_idx holds NR until the next start.
- ERROR: err=1, busy=0. start clears err and goes → WRITE as from IDLE. Without start, ERROR is held.

Rules and boundary conditions:
- Pass timing: with a register whose reg_full rises the edge after the write, each pass is 3+DP_LAT cycles.
- Default latency: 15 passes × 5 = 75 cycles from the start-accept edge to DONE entry.
- start while busy is ignored: no restart, no counter change.
- abort in any busy state → IDLE at the next edge.
  - reg_wr_en and reg_rd_en are deasserted that edge; done is not pulsed and round_idx holds.
  - abort in IDLE, DONE or ERROR has no effect.
- start and abort in the same IDLE cycle: abort wins, stay IDLE.
- reg_wr_en and reg_rd_en are never high in the same cycle, and each is at most one cycle wide.
- round_idx never exceeds NR. last_round is a combinational decode of the registered round_idx.
- If reg_full is already 1 in WRITE (stale data), the transition to WAIT_FULL is unchanged. The next cycle then proceeds to READ, so the register contents are consumed.

Test Plan:
- Nominal run, defaults, 1-cycle register model: start pulse → 15 wr_en pulses and 15 rd_en pulses.
  - round_idx steps 0..14; in_sel=0 only on the first write.
  - 14 key_req pulses; last_round high during round 14.
  - done is a single pulse exactly 75 cycles after the start edge; busy low afterwards.
- Timeout: reg_full held 0 → ERROR reached 8 cycles after WRITE; err=1, busy=0, no done. A new start clears err and a nominal run completes.
- Abort: abort asserted in COMPUTE of round 5 → IDLE next edge; no done; a subsequent start runs a full 75-cycle operation from round 0.
- Ignored start and start/abort collision: start pulses at rounds 3 and 9 of a run cause no change (done still at cycle 75). start=abort=1 in IDLE → stays IDLE.
- Async reset in WAIT_FULL of round 7: all outputs 0 before the next clk edge; after resetn release with start, a nominal run completes.
- Parameter sweep DP_LAT=1 and DP_LAT=4: done at 60 and 105 cycles respectively; COMPUTE length matches DP_LAT in every round.
